// File: rtl/alu_share_ctrl_pkg.sv
// alu_share_ctrl_pkg: opcodes and FSM state encoding shared by the ALU sharing controller
package alu_share_ctrl_pkg;
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/alu_flag_core.sv
// alu_flag_core: combinational AND/OR/ADD/SUB unit with carry/borrow and zero flags
module alu_flag_core
  import alu_share_ctrl_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             flag,
  output logic             zero
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    // the extra bit of the widened difference is the borrow, i.e. a < b
    diff = {1'b0, a} - {1'b0, b};
    y    = op == OP_AND ? a & b : op == OP_OR ? a | b : op == OP_ADD ? sum[WIDTH-1:0] : diff[WIDTH-1:0];
    flag = op == OP_ADD ? sum[WIDTH] : op == OP_SUB ? diff[WIDTH] : 1'b0;
    zero = y == '0;
  end
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one ALU between two requesters,
// with a registered result returned over a valid/ready handshake.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             res_flag,
  output logic             res_zero,
  output logic             busy
);
  state_t           state;
  logic             last_grant;
  logic             grant;
  logic             any_valid;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic [1:0]       cap_op;
  logic             cap_id;
  logic [WIDTH-1:0] alu_y;
  logic             alu_flag;
  logic             alu_zero;
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant     = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
  end
  assign req0_ready = !rst && state == IDLE && any_valid && !grant;
  assign req1_ready = !rst && state == IDLE && any_valid && grant;
  assign res_valid  = state == DONE;
  assign busy       = state != IDLE;
  alu_flag_core #(.WIDTH(WIDTH)) u_alu (
    .a    (cap_a),
    .b    (cap_b),
    .op   (cap_op),
    .y    (alu_y),
    .flag (alu_flag),
    .zero (alu_zero)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cap_a      <= '0;
      cap_b      <= '0;
      cap_op     <= '0;
      cap_id     <= 1'b0;
      res_data   <= '0;
      res_id     <= 1'b0;
      res_flag   <= 1'b0;
      res_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_valid) begin
          cap_a      <= grant ? req1_a : req0_a;
          cap_b      <= grant ? req1_b : req0_b;
          cap_op     <= grant ? req1_op : req0_op;
          cap_id     <= grant;
          last_grant <= grant;
          state      <= EXEC;
        end
        EXEC: begin
          res_data <= alu_y;
          res_flag <= alu_flag;
          res_zero <= alu_zero;
          res_id   <= cap_id;
          state    <= DONE;
        end
        DONE: if (res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: randomized and directed checks of alu_share_ctrl against a
// transaction-level model of the arbiter and ALU.
module tb_alu_share_ctrl;
  localparam int W = 2;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, res_ready = 1;
  logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [1:0] req0_op = 0, req1_op = 0;
  logic req0_ready, req1_ready, res_valid, res_id, res_flag, res_zero, busy;
  logic [W-1:0] res_data;
  int n_checks = 0, n_fail = 0;

  alu_share_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .res_flag(res_flag), .res_zero(res_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  typedef struct {int data; int id; int flag; int zero;} res_t;

  // Operation result straight from the arithmetic definition of each opcode.
  function automatic res_t model_res(int a, int b, int op, int id);
    res_t r;
    r.id = id;
    case (op)
      0: begin r.data = a & b; r.flag = 0; end
      1: begin r.data = a | b; r.flag = 0; end
      2: begin r.data = (a + b) % (1 << W); r.flag = int'((a + b) >= (1 << W)); end
      default: begin r.data = (a - b + (1 << W)) % (1 << W); r.flag = int'(a < b); end
    endcase
    r.zero = int'(r.data == 0);
    return r;
  endfunction

  // Model: an accepted op occupies the ALU; m_age 0 = computing, 1 = result offered.
  bit   m_pend = 0;
  int   m_age = 0;
  int   m_last = 1;
  res_t m_out = '{0, 0, 0, 0};
  res_t m_next = '{0, 0, 0, 0};

  function automatic int m_grant();
    if (req0_valid && req1_valid) return m_last == 1 ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int g;
    if (rst) begin
      m_pend = 0; m_age = 0; m_last = 1; m_out = '{0, 0, 0, 0};
    end else if (!m_pend) begin
      g = m_grant();
      if (g >= 0) begin
        m_pend = 1; m_age = 0; m_last = g;
        m_next = g == 1 ? model_res(req1_a, req1_b, req1_op, 1) : model_res(req0_a, req0_b, req0_op, 0);
      end
    end else if (m_age == 0) begin
      m_age = 1; m_out = m_next;
    end else if (res_ready) m_pend = 0;
  end

  always @(negedge clk) begin
    int g;
    g = m_grant();
    chk("ready0", req0_ready, int'(!rst && !m_pend && g == 0));
    chk("ready1", req1_ready, int'(!rst && !m_pend && g == 1));
    chk("one_ready", req0_ready & req1_ready, 0);
    chk("res_valid", res_valid, int'(m_pend && m_age == 1));
    chk("busy", busy, int'(m_pend));
    chk("res_data", res_data, m_out.data);
    chk("res_id", res_id, m_out.id);
    chk("res_flag", res_flag, m_out.flag);
    chk("res_zero", res_zero, m_out.zero);
  end

  task automatic set(int id, bit v, int a, int b, int op);
    if (id == 0) begin req0_valid = v; req0_a = W'(a); req0_b = W'(b); req0_op = 2'(op); end
    else begin req1_valid = v; req1_a = W'(a); req1_b = W'(b); req1_op = 2'(op); end
  endtask

  task automatic wait_ready(int id, output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id == 0 ? req0_ready : req1_ready) begin ok = 1; break; end
    end
    if (!ok) timeout("wait_ready");
  endtask

  task automatic do_op(int id, int a, int b, int op, int ed, int ef, int ez);
    bit ok;
    @(posedge clk); #1;
    set(id, 1, a, b, op);
    wait_ready(id, ok);
    @(posedge clk); #1;
    set(id, 0, 0, 0, 0);
    @(negedge clk);
    chk("lat_exec_valid", res_valid, 0);
    @(negedge clk);
    chk("lat_done_valid", res_valid, 1);
    chk("op_data", res_data, ed);
    chk("op_flag", res_flag, ef);
    chk("op_zero", res_zero, ez);
    chk("op_id", res_id, id);
  endtask

  initial begin
    bit ok;
    int ids[$];
    int cycs[$];
    // reset state
    @(negedge clk);
    chk("rst_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", res_data, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    // pin the model with hand-computed results
    do_op(0, 3, 2, 2, 1, 1, 0);
    do_op(1, 1, 2, 3, 3, 1, 0);
    do_op(1, 2, 1, 0, 0, 0, 1);
    do_op(1, 2, 1, 1, 3, 0, 0);
    // result held while consumer stalls; req1 waits meanwhile
    @(posedge clk); #1;
    res_ready = 0;
    set(0, 1, 1, 1, 2);
    wait_ready(0, ok);
    @(posedge clk); #1;
    set(0, 0, 0, 0, 0);
    set(1, 1, 3, 3, 0);
    repeat (2) @(negedge clk);
    chk("hold_first_valid", res_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, 2);
      chk("hold_busy", busy, 1);
      chk("hold_ready0", req0_ready, 0);
      chk("hold_ready1", req1_ready, 0);
    end
    @(posedge clk); #1;
    res_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("release_busy", busy, 0);
    chk("release_valid", res_valid, 0);
    chk("release_ready1", req1_ready, 1);
    @(posedge clk); #1;
    set(1, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("waiter_data", res_data, 3);
    chk("waiter_id", res_id, 1);
    // both valid continuously: alternate grants every 3 cycles
    @(posedge clk); #1;
    set(0, 1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    set(1, 1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (res_valid) begin ids.push_back(int'(res_id)); cycs.push_back(c); end
      @(posedge clk); #1;
      set(0, 1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      set(1, 1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    if (ids.size() < 4) timeout("rr_results");
    else for (int k = 0; k < 4; k++) begin
      chk("rr_id", ids[k], k % 2);
      if (k > 0) chk("rr_spacing", cycs[k] - cycs[k-1], 3);
    end
    // reset while req1's op is executing
    set(0, 0, 0, 0, 0);
    set(1, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 set(1, 1, 1, 1, 2);
    wait_ready(1, ok);
    @(posedge clk); #2;
    rst = 1;
    #1;
    chk("arst_valid", res_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready1", req1_ready, 0);
    chk("arst_data", res_data, 0);
    chk("arst_id", res_id, 0);
    @(posedge clk); #1;
    rst = 0;
    set(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", res_valid, 0);
    end
    @(posedge clk); #1;
    set(0, 1, 2, 3, 3);
    set(1, 1, 3, 2, 3);
    @(negedge clk);
    chk("post_rst_ready0", req0_ready, 1);
    chk("post_rst_ready1", req1_ready, 0);
    // randomized traffic, checked every cycle by the model
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      res_ready = $urandom_range(0, 3) != 0;
      set(0, $urandom_range(0, 2) != 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      set(1, $urandom_range(0, 2) != 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    @(posedge clk); #1;
    res_ready = 1;
    set(0, 0, 0, 0, 0);
    set(1, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
